// File: rtl/gigatron_video_capture.sv
// gigatron_video_capture
// Sink side of the Gigatron CPU video port. Samples the OUT register on every
// ready cycle, recovers frame/line timing from the rising edges of the
// active-low syncs and streams visible pixels into a framebuffer RAM.
//
// Handshake: there is no back-pressure. A pixel sampled on a clock with
// i_ready=1 appears one clock later as a single-cycle o_fb_we strobe with
// o_fb_addr/o_fb_data valid in that same clock; the RAM must accept it.
//
// Optional build macro VIDEO_CAPTURE_DOWNSCALE_EN: keep only every fourth
// line, so a 480-line frame lands in a 160x120 framebuffer.
//
// ADDR_WIDTH must satisfy 2**ADDR_WIDTH >= H_PIXELS*V_LINES.
module gigatron_video_capture #(
    parameter int H_PIXELS   = 160,
    parameter int V_LINES    = 480,
    parameter int H_BP       = 12,
    parameter int V_BP       = 33,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_ready,
    input  logic [7:0]            i_out,
    output logic [ADDR_WIDTH-1:0] o_fb_addr,
    output logic [5:0]            o_fb_data,
    output logic                  o_fb_we,
    output logic                  o_frame_done,
    output logic                  o_frame_err,
    output logic                  o_locked,
    output logic [9:0]            o_line
);
    typedef enum logic [2:0] {
        WAIT_VSYNC,
        V_PORCH,
        H_PORCH,
        ACTIVE,
        WAIT_HSYNC
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(H_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_PIXELS);
    localparam logic [9:0]            LINE_LAST = 10'(V_LINES - 1);
    localparam logic [9:0]            V_BP_CNT  = 10'(V_BP);
    localparam logic [9:0]            H_BP_LAST = 10'((H_BP > 0) ? (H_BP - 1) : 0);

    state_t                  state_q, state_d;
    // Previous sample of the two sync bits only; the colour bits of the
    // previous sample are never consulted. Reset value 2'b11 = syncs inactive.
    logic [1:0]              sync_q, sync_d;
    logic [9:0]              porch_q, porch_d;
    logic [9:0]              hcnt_q, hcnt_d;
    logic [ADDR_WIDTH-1:0]   col_q, col_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [9:0]              line_q, line_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [5:0]              data_q, data_d;
    logic                    we_q, we_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    locked_q, locked_d;

    logic                    hs_rise;
    logic                    vs_rise;
    logic                    line_kept;
    logic                    base_step;
    logic                    end_line;
    logic                    start_line;

    assign hs_rise = ~sync_q[0] & i_out[6];
    assign vs_rise = ~sync_q[1] & i_out[7];

`ifdef VIDEO_CAPTURE_DOWNSCALE_EN
    // One line in four is stored; the base moves on after the fourth line.
    assign line_kept = (line_q[1:0] == 2'b00);
    assign base_step = (line_q[1:0] == 2'b11);
`else
    assign line_kept = 1'b1;
    assign base_step = 1'b1;
`endif

    assign o_fb_addr    = addr_q;
    assign o_fb_data    = data_q;
    assign o_fb_we      = we_q;
    assign o_frame_done = done_q;
    assign o_frame_err  = err_q;
    assign o_locked     = locked_q;
    assign o_line       = line_q;

    // Next-state and output decode; nothing advances on a non-ready clock.
    always_comb begin
        state_d    = state_q;
        sync_d     = sync_q;
        porch_d    = porch_q;
        hcnt_d     = hcnt_q;
        col_d      = col_q;
        base_d     = base_q;
        line_d     = line_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        locked_d   = locked_q;
        end_line   = 1'b0;
        start_line = 1'b0;

        if (i_ready) begin
            sync_d = i_out[7:6];
            if (vs_rise && (state_q != WAIT_VSYNC)) begin
                // Early vsync: abandon the frame and re-align on this edge.
                err_d    = 1'b1;
                locked_d = 1'b0;
                state_d  = V_PORCH;
                porch_d  = '0;
                line_d   = '0;
                base_d   = '0;
                col_d    = '0;
            end else begin
                case (state_q)
                    WAIT_VSYNC: begin
                        if (vs_rise) begin
                            state_d = V_PORCH;
                            porch_d = '0;
                            line_d  = '0;
                            base_d  = '0;
                            col_d   = '0;
                        end
                    end
                    V_PORCH: begin
                        if (hs_rise) begin
                            if (porch_q == V_BP_CNT) begin
                                start_line = 1'b1;
                            end else begin
                                porch_d = porch_q + 10'd1;
                            end
                        end
                    end
                    H_PORCH: begin
                        if (hs_rise) begin
                            end_line = 1'b1;
                        end else if (hcnt_q == H_BP_LAST) begin
                            state_d = ACTIVE;
                        end else begin
                            hcnt_d = hcnt_q + 10'd1;
                        end
                    end
                    ACTIVE: begin
                        if (hs_rise) begin
                            // Short line: the edge sample itself is not a pixel.
                            end_line = 1'b1;
                        end else begin
                            if (line_kept) begin
                                we_d   = 1'b1;
                                addr_d = base_q + col_q;
                                data_d = i_out[5:0];
                            end
                            if (col_q == COL_LAST) begin
                                end_line = 1'b1;
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    end
                    WAIT_HSYNC: begin
                        if (hs_rise) begin
                            start_line = 1'b1;
                        end
                    end
                    default: begin
                        state_d = WAIT_VSYNC;
                    end
                endcase

                if (end_line) begin
                    line_d = line_q + 10'd1;
                    col_d  = '0;
                    if (base_step) begin
                        base_d = base_q + LINE_STEP;
                    end
                    // The frame-complete check wins over restarting a short line.
                    if (line_q == LINE_LAST) begin
                        state_d  = WAIT_VSYNC;
                        done_d   = 1'b1;
                        locked_d = 1'b1;
                    end else if (hs_rise) begin
                        start_line = 1'b1;
                    end else begin
                        state_d = WAIT_HSYNC;
                    end
                end

                if (start_line) begin
                    state_d = (H_BP == 0) ? ACTIVE : H_PORCH;
                    hcnt_d  = '0;
                    col_d   = '0;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= WAIT_VSYNC;
            sync_q   <= 2'b11;
            porch_q  <= '0;
            hcnt_q   <= '0;
            col_q    <= '0;
            base_q   <= '0;
            line_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            porch_q  <= porch_d;
            hcnt_q   <= hcnt_d;
            col_q    <= col_d;
            base_q   <= base_d;
            line_q   <= line_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            done_q   <= done_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

endmodule

// File: tb/tb_gigatron_video_capture.sv
// Bench for gigatron_video_capture with a small 4x3 frame geometry
// (4x8 when VIDEO_CAPTURE_DOWNSCALE_EN is defined). Expected framebuffer
// writes are queued as stimulus is driven and compared as writes appear.
module tb_gigatron_video_capture;
    localparam int H_PIXELS = 4;
`ifdef VIDEO_CAPTURE_DOWNSCALE_EN
    localparam int V_LINES  = 8;
`else
    localparam int V_LINES  = 3;
`endif
    localparam int H_BP     = 2;
    localparam int V_BP     = 1;
    localparam int AW       = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          rdy = 1'b0;
    logic [7:0]    din = 8'hC0;
    logic [AW-1:0] o_fb_addr;
    logic [5:0]    o_fb_data;
    logic          o_fb_we;
    logic          o_frame_done;
    logic          o_frame_err;
    logic          o_locked;
    logic [9:0]    o_line;

    gigatron_video_capture #(
        .H_PIXELS  (H_PIXELS),
        .V_LINES   (V_LINES),
        .H_BP      (H_BP),
        .V_BP      (V_BP),
        .ADDR_WIDTH(AW)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_ready     (rdy),
        .i_out       (din),
        .o_fb_addr   (o_fb_addr),
        .o_fb_data   (o_fb_data),
        .o_fb_we     (o_fb_we),
        .o_frame_done(o_frame_done),
        .o_frame_err (o_frame_err),
        .o_locked    (o_locked),
        .o_line      (o_line)
    );

    // ---------------- scoreboard ----------------
    logic [AW+5:0] exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    int  err_cnt  = 0;
    int  wr_cnt   = 0;
    int  exp_last_addr;
    bit  gaps     = 1'b0;
    logic last_rdy = 1'b0;

`ifdef VIDEO_CAPTURE_DOWNSCALE_EN
    initial exp_last_addr = (V_LINES / 4) * H_PIXELS - 1;
`else
    initial exp_last_addr = H_PIXELS * V_LINES - 1;
`endif

    always @(posedge clk) last_rdy <= rdy;

    always @(negedge clk) begin
        logic [AW+5:0] e;
        if (o_fb_we) begin
            wr_cnt++;
            n_checks++;
            if (last_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL we_after_ready: write at addr %0d follows a non-ready clock", o_fb_addr);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", o_fb_addr, o_fb_data);
            end else begin
                e = exp_q.pop_front();
                if ({o_fb_addr, o_fb_data} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr %0d data %0d, expected addr %0d data %0d",
                             o_fb_addr, o_fb_data, e[AW+5:6], e[5:0]);
                end
            end
        end
        if (o_frame_done) begin
            done_cnt++;
            n_checks++;
            if (o_fb_addr !== AW'(exp_last_addr)) begin
                n_fail++;
                $display("FAIL done_position: done with addr %0d, expected %0d", o_fb_addr, exp_last_addr);
            end
        end
        if (o_frame_err) err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic [7:0] v, input logic r);
        din = v;
        rdy = r;
        @(posedge clk);
        #1;
    endtask

    // One ready sample; in gap mode each is followed by a non-ready clock of noise.
    task automatic send(input logic [7:0] v);
        step(v, 1'b1);
        if (gaps) step(8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic vsync_pulse();
        send(8'h40);
        send(8'hC0);
    endtask

    task automatic hsync_pulse();
        send(8'h80);
        send(8'hC0);
    endtask

    task automatic push(input int addr, input int val);
        exp_q.push_back({AW'(addr), 6'(val)});
    endtask

    task automatic pix(input int val, input int addr, input bit wr);
        if (wr) push(addr, val);
        send(8'hC0 | 8'(val));
    endtask

    // Horizontal porch then a full line of pixels 1..H_PIXELS.
    task automatic line_body(input int l);
        bit wr;
        int base;
`ifdef VIDEO_CAPTURE_DOWNSCALE_EN
        wr   = (l % 4) == 0;
        base = (l / 4) * H_PIXELS;
`else
        wr   = 1'b1;
        base = l * H_PIXELS;
`endif
        for (int i = 0; i < H_BP; i++) send(8'hC0);
        for (int c = 0; c < H_PIXELS; c++) pix(c + 1, base + c, wr);
    endtask

    task automatic full_line(input int l);
        hsync_pulse();
        line_body(l);
    endtask

    task automatic frame();
        vsync_pulse();
        for (int i = 0; i < V_BP; i++) hsync_pulse();
        for (int l = 0; l < V_LINES; l++) full_line(l);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(8'hC0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        step(8'hC0, 1'b1);
        step(8'hC0, 1'b1);
        n_checks++;
        if ({o_fb_we, o_frame_done, o_frame_err, o_locked} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got we/done/err/locked %b, expected 0000",
                     {o_fb_we, o_frame_done, o_frame_err, o_locked});
        end
        n_checks++;
        if ({o_fb_addr, o_fb_data, o_line} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got addr %0d data %0d line %0d, expected 0 0 0",
                     o_fb_addr, o_fb_data, o_line);
        end
        rst = 1'b0;
    endtask

    task automatic check_frame_end(input string name, input int done0, input int err0);
        idle(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_writes: %0d writes outstanding, expected 0", name, exp_q.size());
        end
        n_checks++;
        if (done_cnt != done0 + 1) begin
            n_fail++;
            $display("FAIL %s_done: got %0d done pulses, expected 1", name, done_cnt - done0);
        end
        n_checks++;
        if (err_cnt != err0) begin
            n_fail++;
            $display("FAIL %s_err: got %0d err pulses, expected 0", name, err_cnt - err0);
        end
        n_checks++;
        if (o_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_locked: got %b, expected 1", name, o_locked);
        end
        n_checks++;
        if (o_line !== 10'(V_LINES)) begin
            n_fail++;
            $display("FAIL %s_line: got %0d, expected %0d", name, o_line, V_LINES);
        end
    endtask

    task automatic test_clean_frame();
        int d0 = done_cnt;
        int e0 = err_cnt;
        n_checks++;
        if (o_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_unlocked_before: got %b, expected 0", o_locked);
        end
        frame();
        check_frame_end("clean", d0, e0);
    endtask

    task automatic test_ready_gaps();
        int d0 = done_cnt;
        int e0 = err_cnt;
        gaps = 1'b1;
        frame();
        check_frame_end("gaps", d0, e0);
        gaps = 1'b0;
    endtask

    task automatic test_short_line();
        int d0 = done_cnt;
        int e0 = err_cnt;
        vsync_pulse();
        hsync_pulse();
        hsync_pulse();
        for (int i = 0; i < H_BP; i++) send(8'hC0);
        pix(1, 0, 1'b1);
        // Second pixel carries hsync low; the next sample is the early rise.
        push(1, 2);
        send(8'h82);
        send(8'hC0);
        line_body(1);
        full_line(2);
        check_frame_end("short", d0, e0);
    endtask

    task automatic test_early_vsync();
        int d0 = done_cnt;
        int e0 = err_cnt;
        vsync_pulse();
        hsync_pulse();
        full_line(0);
        hsync_pulse();
        for (int i = 0; i < H_BP; i++) send(8'hC0);
        pix(1, H_PIXELS, 1'b1);
        // Second pixel carries vsync low; the next sample is the early rise.
        push(H_PIXELS + 1, 2);
        send(8'h42);
        send(8'hC0);
        send(8'hC0);
        n_checks++;
        if (err_cnt != e0 + 1) begin
            n_fail++;
            $display("FAIL early_err: got %0d err pulses, expected 1", err_cnt - e0);
        end
        n_checks++;
        if (o_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL early_locked: got %b, expected 0", o_locked);
        end
        n_checks++;
        if (o_line !== 10'd0) begin
            n_fail++;
            $display("FAIL early_line: got %0d, expected 0", o_line);
        end
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL early_no_done: got %0d done pulses, expected 0", done_cnt - d0);
        end
        // Already in vertical porch: one porch hsync, then a full frame from addr 0.
        hsync_pulse();
        for (int l = 0; l < V_LINES; l++) full_line(l);
        check_frame_end("early_recover", d0, e0 + 1);
    endtask

    task automatic test_reset_mid_line();
        int d0 = done_cnt;
        int w0;
        vsync_pulse();
        hsync_pulse();
        hsync_pulse();
        for (int i = 0; i < H_BP; i++) send(8'hC0);
        pix(1, 0, 1'b1);
        rst = 1'b1;
        step(8'hC2, 1'b1);
        n_checks++;
        if ({o_fb_we, o_frame_done, o_frame_err, o_locked} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_flags: got we/done/err/locked %b, expected 0000",
                     {o_fb_we, o_frame_done, o_frame_err, o_locked});
        end
        n_checks++;
        if ({o_fb_addr, o_fb_data, o_line} !== '0) begin
            n_fail++;
            $display("FAIL midreset_values: got addr %0d data %0d line %0d, expected 0 0 0",
                     o_fb_addr, o_fb_data, o_line);
        end
        rst = 1'b0;
        w0 = wr_cnt;
        for (int k = 0; k < 3; k++) begin
            hsync_pulse();
            for (int i = 0; i < 2 * H_PIXELS; i++) send(8'hC0 | 8'($urandom_range(0, 63)));
        end
        n_checks++;
        if (wr_cnt != w0) begin
            n_fail++;
            $display("FAIL midreset_no_write: got %0d writes before vsync, expected 0", wr_cnt - w0);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_pre_write: %0d writes outstanding, expected 0", exp_q.size());
        end
        frame();
        check_frame_end("midreset", d0, err_cnt);
    endtask

`ifdef VIDEO_CAPTURE_DOWNSCALE_EN
    task automatic test_downscale();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int w0 = wr_cnt;
        frame();
        check_frame_end("downscale", d0, e0);
        n_checks++;
        if (wr_cnt - w0 != 2 * H_PIXELS) begin
            n_fail++;
            $display("FAIL downscale_write_count: got %0d, expected %0d", wr_cnt - w0, 2 * H_PIXELS);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
`ifdef VIDEO_CAPTURE_DOWNSCALE_EN
        test_downscale();
`else
        test_clean_frame();
        test_ready_gaps();
        test_short_line();
        test_early_vsync();
        test_reset_mid_line();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
